// File: rtl/cycle_timing_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : cycle_timing_sequencer_if
//  Description : Bus/control bundle between RDY logic, decode and the
//                cycle timing sequencer (inputs from the core, strobes out).
//  Revision    : 1.0 - initial release
// ============================================================================
interface cycle_timing_sequencer_if #(
  parameter int NUM_T = 8
);
  localparam int c_step_w = $clog2(NUM_T);

  logic                rdy;
  logic                rw;
  logic                tz_pre_n;
  logic                t_end;
  logic                t_abort;
  logic [NUM_T-1:0]    timing_n;
  logic                sync;
  logic                fetch;
  logic [c_step_w-1:0] step;
  logic                last;
  logic                overrun;

  // Core side: drives bus status and decode hints, consumes strobes.
  modport master (
    output rdy, rw, tz_pre_n, t_end, t_abort,
    input  timing_n, sync, fetch, step, last, overrun
  );

  // Sequencer side.
  modport slave (
    input  rdy, rw, tz_pre_n, t_end, t_abort,
    output timing_n, sync, fetch, step, last, overrun
  );
endinterface
`default_nettype wire

// File: rtl/cycle_timing_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cycle_timing_sequencer
//  Description : Per-instruction cycle-step strobe generator. One-hot step
//                vector T1..T(NUM_T-1) plus a T0 (last cycle) flag, with RDY
//                stalls, abort restart, forced end and sticky overrun.
//  Revision    : 1.0 - initial release
// ============================================================================
module cycle_timing_sequencer #(
  parameter int NUM_T          = 8,
  parameter bit STALL_ON_WRITE = 1'b0
) (
  input  logic                     clk,
  input  logic                     res_n,
  cycle_timing_sequencer_if.slave  bus
);

  localparam int c_step_w = $clog2(NUM_T);
  localparam logic [NUM_T-1:1] c_s_t1 = {{(NUM_T-2){1'b0}}, 1'b1};
  localparam logic [NUM_T-1:1] c_s_t2 = {{(NUM_T-3){1'b0}}, 2'b10};

  logic [NUM_T-1:1]    r_s;
  logic                r_t0;
  logic                r_overrun;
  logic [NUM_T-1:1]    w_s_nxt;
  logic                w_t0_nxt;
  logic                w_overrun_nxt;
  logic                w_adv;
  logic [c_step_w-1:0] w_step;

  // Write cycles may bypass RDY so a stall only ever freezes reads by default.
  assign w_adv = bus.rdy | (~bus.rw & ~STALL_ON_WRITE);

  // State register: reset parks the sequencer in T1 so the first cycle fetches.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_s       <= c_s_t1;
      r_t0      <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_s       <= w_s_nxt;
      r_t0      <= w_t0_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  // Next-state: abort beats stall, stall beats everything else.
  always_comb begin
    w_s_nxt       = r_s;
    w_t0_nxt      = r_t0;
    w_overrun_nxt = r_overrun;
    if (bus.t_abort) begin
      w_s_nxt  = c_s_t1;
      w_t0_nxt = 1'b0;
    end else if (!w_adv) begin
      w_s_nxt  = r_s;
      w_t0_nxt = r_t0;
    end else if (r_t0) begin
      // Final cycle done: next instruction starts with an opcode fetch.
      w_s_nxt  = c_s_t1;
      w_t0_nxt = 1'b0;
    end else if (r_s[1]) begin
      // Two-cycle ops overlap T0 with T2 straight after the fetch.
      w_s_nxt  = c_s_t2;
      w_t0_nxt = ~bus.tz_pre_n | bus.t_end;
    end else if (r_s[NUM_T-1]) begin
      // Out of steps: force a T0-only cycle and remember the missing t_end.
      w_s_nxt  = '0;
      w_t0_nxt = 1'b1;
      if (!bus.t_end) begin
        w_overrun_nxt = 1'b1;
      end
    end else begin
      w_s_nxt  = {r_s[NUM_T-2:1], 1'b0};
      w_t0_nxt = bus.t_end;
    end
  end

  // Outputs: pure decodes of registered state, except fetch which needs adv.
  always_comb begin
    w_step = '0;
    for (int i = 1; i < NUM_T; i++) begin
      if (r_s[i]) begin
        w_step = w_step | c_step_w'(i);
      end
    end
    bus.timing_n = ~{r_s, r_t0};
    bus.sync     = r_s[1];
    bus.fetch    = r_s[1] & w_adv;
    bus.step     = w_step;
    bus.last     = r_t0;
    bus.overrun  = r_overrun;
  end

endmodule
`default_nettype wire

// File: tb/tb_cycle_timing_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cycle_timing_sequencer
//  Description : Self-checking bench for cycle_timing_sequencer. Two DUTs
//                (read-only stall and stall-on-write) share one stimulus and
//                are compared to a step-index reference model, a vector
//                table and hand-written corner sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cycle_timing_sequencer;

  localparam int NUM_T = 8;

  typedef struct {
    bit         rdy;
    bit         rw;
    bit         tz;
    bit         te;
    bit         ab;
    logic [7:0] tn;
    logic [2:0] st;
    bit         lst;
  } vec_t;

  logic clk;
  logic res_n;
  int   n_checks;
  int   n_fail;

  bit cur_rdy, cur_rw, cur_tz, cur_te, cur_ab;

  // Reference model: index of the active step (0 = none) plus the last flag.
  int m_step [2];
  bit m_last [2];
  bit m_ovr  [2];

  vec_t tbl[$];

  cycle_timing_sequencer_if #(.NUM_T(NUM_T)) if0 ();
  cycle_timing_sequencer_if #(.NUM_T(NUM_T)) if1 ();

  cycle_timing_sequencer #(.NUM_T(NUM_T), .STALL_ON_WRITE(1'b0)) u_dut0 (
    .clk   (clk),
    .res_n (res_n),
    .bus   (if0)
  );

  cycle_timing_sequencer #(.NUM_T(NUM_T), .STALL_ON_WRITE(1'b1)) u_dut1 (
    .clk   (clk),
    .res_n (res_n),
    .bus   (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_tn(input int st, input bit ls);
    logic [7:0] e;
    e = '1;
    if (st != 0) e[st] = 1'b0;
    if (ls) e[0] = 1'b0;
    return e;
  endfunction

  task automatic set_in(input bit r, input bit rw_, input bit tz, input bit te, input bit ab);
    cur_rdy = r; cur_rw = rw_; cur_tz = tz; cur_te = te; cur_ab = ab;
    if0.rdy = r; if0.rw = rw_; if0.tz_pre_n = tz; if0.t_end = te; if0.t_abort = ab;
    if1.rdy = r; if1.rw = rw_; if1.tz_pre_n = tz; if1.t_end = te; if1.t_abort = ab;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_step[k] = 1;
      m_last[k] = 1'b0;
      m_ovr[k]  = 1'b0;
    end
  endtask

  // One clock of instruction progress, described in terms of step numbers.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit adv;
      adv = cur_rdy || (!cur_rw && k == 0);
      if (cur_ab) begin
        m_step[k] = 1;
        m_last[k] = 1'b0;
      end else if (adv) begin
        if (m_last[k]) begin
          m_step[k] = 1;
          m_last[k] = 1'b0;
        end else if (m_step[k] == NUM_T - 1) begin
          m_step[k] = 0;
          m_last[k] = 1'b1;
          if (!cur_te) m_ovr[k] = 1'b1;
        end else begin
          m_last[k] = cur_te || (m_step[k] == 1 && !cur_tz);
          m_step[k] = m_step[k] + 1;
        end
      end
    end
  endtask

  task automatic chk_model();
    for (int k = 0; k < 2; k++) begin
      logic [7:0] tn;
      logic [2:0] st;
      logic       sy, fe, la, ov;
      bit         adv;
      if (k == 0) begin
        tn = if0.timing_n; st = if0.step; sy = if0.sync; fe = if0.fetch; la = if0.last; ov = if0.overrun;
      end else begin
        tn = if1.timing_n; st = if1.step; sy = if1.sync; fe = if1.fetch; la = if1.last; ov = if1.overrun;
      end
      adv = cur_rdy || (!cur_rw && k == 0);
      chk($sformatf("model%0d_timing_n", k), 16'(tn), 16'(exp_tn(m_step[k], m_last[k])));
      chk($sformatf("model%0d_step", k), 16'(st), 16'(m_step[k]));
      chk($sformatf("model%0d_sync", k), 16'(sy), 16'(m_step[k] == 1));
      chk($sformatf("model%0d_fetch", k), 16'(fe), 16'(m_step[k] == 1 && adv));
      chk($sformatf("model%0d_last", k), 16'(la), 16'(m_last[k]));
      chk($sformatf("model%0d_overrun", k), 16'(ov), 16'(m_ovr[k]));
    end
  endtask

  // Called just after a rising edge; leaves the bench just after the next one.
  task automatic drive(input bit r, input bit rw_, input bit tz, input bit te, input bit ab);
    set_in(r, rw_, tz, te, ab);
    @(negedge clk);
    chk_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Asynchronous reset in the middle of a cycle, checked before any clock edge.
  task automatic mid_reset(input string tag);
    #2 res_n = 1'b0;
    #1;
    chk({tag, "_tn0"}, 16'(if0.timing_n), 16'h00FD);
    chk({tag, "_tn1"}, 16'(if1.timing_n), 16'h00FD);
    chk({tag, "_step0"}, 16'(if0.step), 16'd1);
    chk({tag, "_sync0"}, 16'(if0.sync), 16'd1);
    chk({tag, "_last0"}, 16'(if0.last), 16'd0);
    chk({tag, "_ovr0"}, 16'(if0.overrun), 16'd0);
    chk({tag, "_ovr1"}, 16'(if1.overrun), 16'd0);
    model_reset();
    @(posedge clk);
    #1 res_n = 1'b1;
  endtask

  task automatic add(input bit r, input bit tz, input bit te, input bit ab,
                     input logic [7:0] tn, input logic [2:0] st, input bit lst);
    vec_t v;
    v.rdy = r; v.rw = 1'b1; v.tz = tz; v.te = te; v.ab = ab;
    v.tn = tn; v.st = st; v.lst = lst;
    tbl.push_back(v);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // rdy tz te ab -> timing_n step last (state after the edge)
    add(1, 0, 0, 0, 8'hFA, 3'd2, 1);  // two-cycle op
    add(1, 1, 0, 0, 8'hFD, 3'd1, 0);
    add(1, 1, 0, 0, 8'hFB, 3'd2, 0);  // t_end in T3
    add(1, 1, 0, 0, 8'hF7, 3'd3, 0);
    add(1, 1, 1, 0, 8'hEE, 3'd4, 1);
    add(1, 1, 0, 0, 8'hFD, 3'd1, 0);
    add(1, 1, 0, 0, 8'hFB, 3'd2, 0);  // read stall in T2
    add(0, 1, 0, 0, 8'hFB, 3'd2, 0);
    add(0, 0, 1, 0, 8'hFB, 3'd2, 0);
    add(0, 1, 0, 0, 8'hFB, 3'd2, 0);
    add(1, 1, 0, 0, 8'hF7, 3'd3, 0);
    add(1, 1, 1, 0, 8'hEE, 3'd4, 1);
    add(1, 1, 1, 0, 8'hFD, 3'd1, 0);  // t_end in T0 ignored
    add(1, 1, 0, 0, 8'hFB, 3'd2, 0);
    add(1, 1, 0, 0, 8'hF7, 3'd3, 0);
    add(1, 1, 0, 0, 8'hEF, 3'd4, 0);
    add(1, 1, 0, 0, 8'hDF, 3'd5, 0);
    add(0, 1, 0, 1, 8'hFD, 3'd1, 0);  // abort while stalled
    add(1, 1, 1, 0, 8'hFA, 3'd2, 1);  // t_end in T1
    add(1, 1, 0, 0, 8'hFD, 3'd1, 0);
    add(1, 0, 0, 0, 8'hFA, 3'd2, 1);
    add(0, 1, 0, 0, 8'hFA, 3'd2, 1);  // stall on T0 keeps last
    add(1, 1, 0, 0, 8'hFD, 3'd1, 0);

    res_n = 1'b0;
    set_in(1, 1, 1, 0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tn", 16'(if0.timing_n), 16'h00FD);
    chk("reset_step", 16'(if0.step), 16'd1);
    chk("reset_last", 16'(if0.last), 16'd0);
    chk("reset_ovr", 16'(if0.overrun), 16'd0);
    res_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].rdy, tbl[i].rw, tbl[i].tz, tbl[i].te, tbl[i].ab);
      chk($sformatf("tbl%0d_tn", i), 16'(if0.timing_n), 16'(tbl[i].tn));
      chk($sformatf("tbl%0d_step", i), 16'(if0.step), 16'(tbl[i].st));
      chk($sformatf("tbl%0d_last", i), 16'(if0.last), 16'(tbl[i].lst));
      chk($sformatf("tbl%0d_sync", i), 16'(if0.sync), 16'(tbl[i].st == 3'd1));
      chk($sformatf("tbl%0d_ovr", i), 16'(if0.overrun), 16'd0);
    end

    // Runaway instruction: no t_end ever.
    repeat (6) drive(1, 1, 1, 0, 0);
    chk("ovr_t7_tn", 16'(if0.timing_n), 16'h007F);
    chk("ovr_t7_step", 16'(if0.step), 16'd7);
    chk("ovr_t7_flag", 16'(if0.overrun), 16'd0);
    drive(1, 1, 1, 0, 0);
    chk("ovr_t0_tn", 16'(if0.timing_n), 16'h00FE);
    chk("ovr_t0_step", 16'(if0.step), 16'd0);
    chk("ovr_t0_last", 16'(if0.last), 16'd1);
    chk("ovr_t0_flag0", 16'(if0.overrun), 16'd1);
    chk("ovr_t0_flag1", 16'(if1.overrun), 16'd1);
    drive(1, 1, 1, 0, 0);
    chk("ovr_next_tn", 16'(if0.timing_n), 16'h00FD);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0);
    repeat (3) drive(1, 1, 1, 0, 0);
    chk("ovr_sticky_step", 16'(if0.step), 16'd4);
    chk("ovr_sticky_flag", 16'(if0.overrun), 16'd1);
    mid_reset("rst_mid_t4");

    // Write-cycle stall immunity differs between the two instances.
    drive(1, 1, 1, 0, 0);
    for (int j = 0; j < 3; j++) begin
      drive(0, 0, 1, 0, 0);
      chk($sformatf("wr_stall%0d_sow0", j), 16'(if0.step), 16'(3 + j));
      chk($sformatf("wr_stall%0d_sow1", j), 16'(if1.step), 16'd2);
    end
    drive(1, 1, 1, 0, 0);
    chk("wr_resume_sow0", 16'(if0.step), 16'd6);
    chk("wr_resume_sow1", 16'(if1.step), 16'd3);

    // Stalled opcode fetch: sync stays, fetch waits for rdy.
    mid_reset("rst_fetch");
    set_in(0, 1, 1, 0, 0);
    #1;
    chk("fetch_stalled", 16'(if0.fetch), 16'd0);
    chk("sync_stalled", 16'(if0.sync), 16'd1);
    set_in(1, 1, 1, 0, 0);
    #1;
    chk("fetch_ready", 16'(if0.fetch), 16'd1);

    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
            $urandom_range(0, 31) == 0);
      if ($urandom_range(0, 199) == 0) mid_reset("rst_rand");
    end
    @(negedge clk);
    chk_model();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
